// File: rtl/uart_frame_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter that frames DIFF / LTH / CHK results onto a byte-wide UART TX core.
// Define FRAME_CSUM_EN to append an XOR checksum byte (TYPE ^ payload) to every frame.
module uart_frame_arb #(
    parameter logic [7:0] HDR0    = 8'hAA,
    parameter logic [7:0] HDR1    = 8'h55,
    parameter int         GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        diff_doe,
    input  logic [15:0] diff_dat,
    input  logic        lth_doe,
    input  logic [54:0] lth_dat,
    input  logic        chk_doe,
    input  logic [63:0] chk_dat,
    input  logic        tx_rdy,
    output logic        tx_wen,
    output logic [7:0]  tx_dat,
    output logic        busy,
    output logic [2:0]  gnt,
    output logic [7:0]  ovf_cnt
);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_WAIT, S_GAP} state_t;
    state_t state, state_nxt;

    logic [15:0]   diff_hold;
    logic [54:0]   lth_hold;
    logic [63:0]   chk_hold;
    logic [2:0]    pend, doe, win, ovf_hit;
    logic [1:0]    last;
    logic [95:0]   shreg, frame;
    logic [3:0]    byte_cnt, frame_len;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    ovf_add;
    logic [8:0]    ovf_sum;

    assign doe = {chk_doe, lth_doe, diff_doe};

    // Search starts at the source after the one granted last.
    always_comb begin
        win = 3'b000;
        case (last)
            2'd0:    win = pend[1] ? 3'b010 : pend[2] ? 3'b100 : pend[0] ? 3'b001 : 3'b000;
            2'd1:    win = pend[2] ? 3'b100 : pend[0] ? 3'b001 : pend[1] ? 3'b010 : 3'b000;
            default: win = pend[0] ? 3'b001 : pend[1] ? 3'b010 : pend[2] ? 3'b100 : 3'b000;
        endcase
    end

    assign gnt     = (state == S_GRANT) ? win : 3'b000;
    assign ovf_hit = doe & pend & ~gnt;
    assign ovf_add = {1'b0, ovf_hit[0]} + {1'b0, ovf_hit[1]} + {1'b0, ovf_hit[2]};
    assign ovf_sum = {1'b0, ovf_cnt} + {7'b0, ovf_add};

`ifdef FRAME_CSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [63:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) acc ^= v[i*8 +: 8];
        return acc;
    endfunction
`endif

    // Frame image is left-justified so bytes leave from the top of the shift register.
    always_comb begin
        frame     = '0;
        frame_len = 4'd0;
        if (win[0]) begin
`ifdef FRAME_CSUM_EN
            frame     = {HDR0, HDR1, 8'h01, diff_hold, xor_bytes({48'b0, diff_hold}) ^ 8'h01, 48'b0};
            frame_len = 4'd6;
`else
            frame     = {HDR0, HDR1, 8'h01, diff_hold, 56'b0};
            frame_len = 4'd5;
`endif
        end else if (win[1]) begin
`ifdef FRAME_CSUM_EN
            frame     = {HDR0, HDR1, 8'h02, 1'b0, lth_hold, xor_bytes({9'b0, lth_hold}) ^ 8'h02, 8'b0};
            frame_len = 4'd11;
`else
            frame     = {HDR0, HDR1, 8'h02, 1'b0, lth_hold, 16'b0};
            frame_len = 4'd10;
`endif
        end else if (win[2]) begin
`ifdef FRAME_CSUM_EN
            frame     = {HDR0, HDR1, 8'h03, chk_hold, xor_bytes(chk_hold) ^ 8'h03};
            frame_len = 4'd12;
`else
            frame     = {HDR0, HDR1, 8'h03, chk_hold, 8'b0};
            frame_len = 4'd11;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_wen    = 1'b0;
        case (state)
            S_IDLE:  if (|pend) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_SEND;
            S_SEND: begin
                if (tx_rdy) begin
                    tx_wen    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT:  state_nxt = (byte_cnt == 4'd0) ? S_GAP : S_SEND;
            S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign tx_dat = tx_wen ? shreg[95:88] : 8'h00;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_hold <= '0;
            lth_hold  <= '0;
            chk_hold  <= '0;
            pend      <= '0;
            last      <= 2'd2;
            ovf_cnt   <= '0;
            shreg     <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            if (diff_doe) diff_hold <= diff_dat;
            if (lth_doe)  lth_hold  <= lth_dat;
            if (chk_doe)  chk_hold  <= chk_dat;
            // A strobe on the source being granted re-arms its pend flag with the new data.
            pend    <= (pend & ~gnt) | doe;
            ovf_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
            if (state == S_GRANT) begin
                shreg    <= frame;
                byte_cnt <= frame_len;
                last     <= win[2] ? 2'd2 : (win[1] ? 2'd1 : 2'd0);
            end
            if (tx_wen) begin
                shreg    <= shreg << 8;
                byte_cnt <= byte_cnt - 4'd1;
            end
            if (state == S_WAIT && byte_cnt == 4'd0) gap_cnt <= GW'(GAP_CYC - 1);
            else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end
endmodule
